// File: rtl/sap2_pkg.sv
// Shared types for the SAP-2 program counter block: default sizes, command
// encoding and the control priority encoder.
package sap2_pkg;

  localparam int unsigned AW_DEF    = 8;
  localparam int unsigned DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLR,
    CMD_RET,
    CMD_CALL,
    CMD_LOAD,
    CMD_INC
  } pc_cmd_e;

  // Exactly one command per edge; the highest-priority raw control wins.
  function automatic pc_cmd_e encode_cmd(input logic clr, input logic ret,
                                         input logic call, input logic lp,
                                         input logic cp);
    pc_cmd_e cmd;
    cmd = CMD_NONE;
    if (clr)       cmd = CMD_CLR;
    else if (ret)  cmd = CMD_RET;
    else if (call) cmd = CMD_CALL;
    else if (lp)   cmd = CMD_LOAD;
    else if (cp)   cmd = CMD_INC;
    return cmd;
  endfunction

endpackage

// File: rtl/lifo_stack.sv
// Register-array LIFO holding return addresses; push when full and pop when
// empty are ignored, the owner reports those as overflow/underflow.
module lifo_stack #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned SPW  = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic [AW-1:0]  din_i,
  output logic [SPW-1:0] sp_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [AW-1:0]  top_o
);

  logic [AW-1:0]  stack_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign sp_o    = sp_q;

  always_comb begin
    sp_d = sp_q;
    if (pop_i && !empty_o)      sp_d = sp_q - 1'b1;
    else if (push_i && !full_o) sp_d = sp_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_i) sp_q <= '0;
    else       sp_q <= sp_d;
  end

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!rst_i && push_i && !pop_i && !full_o && sp_q == SPW'(i))
        stack_q[i] <= din_i;
    end
  end

  always_comb begin
    top_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) top_o = stack_q[i];
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with integrated return-address stack for the SAP-2 datapath.
// Optional top-of-stack peek port (es/top) enabled by defining PC_STACK_PEEK_EN.
module pc_stack
  import sap2_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter logic [AW-1:0] RST_ADDR = '0,
  localparam int unsigned SPW     = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           clr,
  inout  wire  [AW-1:0]  bus,
  input  logic           ep,
  input  logic           lp,
  input  logic           cp,
  input  logic           call,
  input  logic           ret,
`ifdef PC_STACK_PEEK_EN
  input  logic           es,
  output logic [AW-1:0]  top,
`endif
  output logic [AW-1:0]  pc_out,
  output logic [SPW-1:0] sp,
  output logic           full,
  output logic           empty,
  output logic           ovf,
  output logic           unf
);

  pc_cmd_e       cmd;
  logic [AW-1:0] pc_q, pc_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          push, pop;
  logic [AW-1:0] tos;

  assign cmd  = encode_cmd(clr, ret, call, lp, cp);
  assign push = (cmd == CMD_CALL) && !full;
  assign pop  = (cmd == CMD_RET) && !empty;

  lifo_stack #(
    .AW   (AW),
    .DEPTH(DEPTH)
  ) u_lifo (
    .clk    (clk),
    .rst_i  (clr),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (pc_q),
    .sp_o   (sp),
    .full_o (full),
    .empty_o(empty),
    .top_o  (tos)
  );

  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    unique case (cmd)
      CMD_CLR: begin
        pc_d  = RST_ADDR;
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      CMD_RET:  if (empty) unf_d = 1'b1; else pc_d = tos;
      CMD_CALL: if (full)  ovf_d = 1'b1; else pc_d = bus;
      CMD_LOAD: pc_d = bus;
      CMD_INC:  pc_d = pc_q + 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    pc_q  <= pc_d;
    ovf_q <= ovf_d;
    unf_q <= unf_d;
  end

  assign pc_out = pc_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;

`ifdef PC_STACK_PEEK_EN
  assign top = tos;
  // ep has precedence over es, so the two never contend on the bus.
  assign bus = (ep && !lp && !call)                  ? pc_q :
               (es && !ep && !lp && !call && !empty) ? tos  : 'z;
`else
  assign bus = (ep && !lp && !call) ? pc_q : 'z;
`endif

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
Parametrised program counter with an integrated hardware return-address stack. It is the next-generation replacement for the separate 8-bit program counter and subroutine counter in the SAP-2 mini datapath. It supports jump, increment, CALL (push and load) and RET (pop), and detects overflow and underflow. It drives the shared bus and also feeds the memory address register directly.

Parameters:
AW, 8, address width in bits; the PC and every stack entry are AW wide.
DEPTH, 4, number of return-address entries (≥1).
RST_ADDR, 0, PC value after reset.

Ports:
clk  input  1  system clock, all state changes on rising edge.
clr  input  1  synchronous active-high reset.
bus  inout  AW  shared bus; read on lp/call, driven when ep is active.
ep  input  1  enable PC onto bus.
lp  input  1  load PC from bus (jump).
cp  input  1  increment PC.
call  input  1  push PC onto stack, then load PC from bus.
ret  input  1  pop top-of-stack into PC.
pc_out  output  AW  current PC, continuous; feeds the MAR.
sp  output  $clog2(DEPTH+1)  number of valid stack entries.
full  output  1  sp == DEPTH.
empty  output  1  sp == 0.
ovf  output  1  sticky; set by CALL while full.
unf  output  1  sticky; set by RET while empty.

Behaviour:
- Clock and reset: one clock `clk`. Reset `clr` is synchronous and active-high.
- Reset (clr=1 at edge):
  - pc=RST_ADDR, sp=0, ovf=0, unf=0; stack contents are don't-care.
  - clr overrides every other control in that cycle.
- Command priority at each edge, highest first: clr > ret > call > lp > cp. Exactly one action executes; lower-priority requests in the same cycle are dropped.
- ret:
  - If sp>0: pc <= stack[sp-1], sp <= sp-1.
  - If sp==0: pc unchanged, sp unchanged, unf <= 1.
- call:
  - If sp<DEPTH: stack[sp] <= pc, sp <= sp+1, pc <= bus.
  - If sp==DEPTH: no push, pc unchanged, ovf <= 1.
  - The pushed value is the PC as it stands. The sequencer must issue cp past the operand before call, so the pushed address is the return address.
- lp: pc <= bus.
- cp: pc <= pc+1 modulo 2^AW; 2^AW-1 wraps to 0 with no flag.
- No command: all state holds.
- Bus drive: bus = pc when ep && !lp && !call, else high-Z. This is combinational, zero latency. ep together with lp or call never self-drives.
- pc_out, sp, full, empty are registered-state reflections, valid one cycle after the causing edge. All commands take effect at that edge (latency 1).
- ovf and unf:
  - Once set, they clear only on clr.
  - They do not block later valid operations.
- Reset mid-operation: clr asserted in the same cycle as call discards the push; sp=0 after the edge.

Optional Feature:
- Macro: PC_STACK_PEEK_EN.
- Defined:
  - Adds input `es` (1 bit) and output `top` (AW).
  - `top` = stack[sp-1] when sp>0, else 0.
  - es drives `top` onto bus when ep=0, lp=0, call=0 and sp>0; otherwise high-Z.
  - ep together with es: ep wins and es is ignored, so there is no contention.
- Undefined: es and top do not exist; behaviour is otherwise identical.

Decomposition:
- Package sap2_pkg:
  - default AW and DEPTH constants;
  - an enumerated pc_cmd_e type (CMD_NONE, CMD_CLR, CMD_RET, CMD_CALL, CMD_LOAD, CMD_INC);
  - a function that priority-encodes the raw controls into pc_cmd_e.
- One sub-module, lifo_stack:
  - parametrised AW/DEPTH register-array LIFO with push, pop, sp, full, empty and top;
  - pc_stack instantiates it and owns the PC, flags and bus drive.

Test Plan:
- Reset then increment: clr, then cp for 3 cycles -> pc_out 0,1,2,3; sp=0, empty=1, ovf=unf=0.
- Jump and bus drive: bus=8'h5A with lp -> pc_out=5A. Next cycle ep=1 -> bus reads 5A. With ep=0 -> bus is Z.
- Nested call/return with DEPTH=4:
  - pc=10, call with bus=40 -> pc=40, sp=1.
  - pc=41, call with bus=80 -> pc=80, sp=2.
  - ret -> pc=41; ret -> pc=10; sp=0.
- Overflow and underflow:
  - Fill with 4 calls, 5th call with bus=FF -> pc unchanged, sp=4, ovf=1.
  - Empty the stack, extra ret -> pc unchanged, unf=1.
  - Both flags persist until clr.
- Priority and wrap:
  - pc=FF with cp -> 00.
  - ret+call+cp same cycle with top=22 -> pc=22, sp decremented, no push.
  - clr+call -> pc=RST_ADDR, sp=0.
- PEEK (macro defined): after call from pc=33, es=1, ep=0 -> bus=33. With es=1 and ep=1 -> bus=pc.
